// File: rtl/uart_rx_phase.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_phase
// Brief  : UART receiver timed by a phase-accumulator sample tick generator.
// Rev    : 1.0
// ============================================================================
module uart_rx_phase #(
  parameter int SYS_CLK_FREQ = 125000000,
  parameter int BAUD_RATE    = 115200,
  parameter int ACC_WIDTH    = 32,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  // Rounded phase increment; 64-bit so BAUD_RATE << ACC_WIDTH cannot overflow.
  localparam logic [63:0] c_inc_wide =
    ((64'(BAUD_RATE) << ACC_WIDTH) + (64'(SYS_CLK_FREQ) >> 1)) / 64'(SYS_CLK_FREQ);
  localparam logic [ACC_WIDTH-1:0] c_inc  = c_inc_wide[ACC_WIDTH-1:0];
  localparam logic [ACC_WIDTH-1:0] c_half = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam int                   c_cnt_w = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [c_cnt_w-1:0]   c_last  = c_cnt_w'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t                 state_q,     state_d;
  logic                   sync1_q,     sync1_d;
  logic                   sync2_q,     sync2_d;
  logic                   prev_q,      prev_d;
  logic [ACC_WIDTH-1:0]   acc_q,       acc_d;
  logic [c_cnt_w-1:0]     cnt_q,       cnt_d;
  logic [DATA_BITS-1:0]   shift_q,     shift_d;
  logic [DATA_BITS-1:0]   rx_data_q,   rx_data_d;
  logic                   rx_valid_q,  rx_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q,   overrun_d;
  logic                   busy_q,      busy_d;

  logic [ACC_WIDTH:0]     acc_sum;
  logic                   tick;
  logic                   deliver;

  always_comb begin
    sync1_d     = rxd;
    sync2_d     = sync1_q;
    prev_d      = sync2_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    deliver     = 1'b0;
    acc_sum     = {1'b0, acc_q} + {1'b0, c_inc};
    tick        = acc_sum[ACC_WIDTH];

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (prev_q && !sync2_q) begin
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          if (!sync2_q) begin
            state_d = DATA;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          // LSB arrives first, so shifting in at the MSB leaves it at bit 0.
          shift_d = {sync2_q, shift_q[DATA_BITS-1:1]};
          if (cnt_q == c_last) begin
            state_d = STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (sync2_q) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (sync2_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (deliver) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    // Preload half a bit period whenever idle so the first carry is mid start bit.
    acc_d  = (state_q == IDLE || state_d == IDLE) ? c_half : acc_sum[ACC_WIDTH-1:0];
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      acc_q       <= c_half;
      cnt_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_phase.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_uart_rx_phase
// Brief  : Directed + randomized bench for uart_rx_phase against a frame-level model.
// Rev    : 1.0
// ============================================================================
module tb_uart_rx_phase;

  localparam int BIT  = 1085;
  localparam int FBIT = 16;
  localparam int FW   = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic          rxd, rx_ready;
  logic [7:0]    rx_data;
  logic          rx_valid, frame_err, overrun, busy;
  logic          rxd_f, rx_ready_f;
  logic [FW-1:0] rx_data_f;
  logic          rx_valid_f, frame_err_f, overrun_f, busy_f;

  always #4 clk = ~clk;

  uart_rx_phase #(
    .SYS_CLK_FREQ(125000000), .BAUD_RATE(115200), .ACC_WIDTH(32), .DATA_BITS(8)
  ) u_dut (
    .clk(clk), .reset(reset), .rxd(rxd), .rx_ready(rx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  // 16 clocks per bit keeps the randomized run short.
  uart_rx_phase #(
    .SYS_CLK_FREQ(1843200), .BAUD_RATE(115200), .ACC_WIDTH(32), .DATA_BITS(FW)
  ) u_dut_fast (
    .clk(clk), .reset(reset), .rxd(rxd_f), .rx_ready(rx_ready_f), .rx_data(rx_data_f),
    .rx_valid(rx_valid_f), .frame_err(frame_err_f), .overrun(overrun_f), .busy(busy_f)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_vcyc = 0, n_vrise = 0, n_fe = 0, n_ovr = 0, n_got = 0;
  int         vrise_cyc = 0, bfall_cyc = 0;
  logic [7:0] got_mem [0:63];
  logic       pv = 1'b0, pb = 1'b0;
  always @(negedge clk) begin
    if (rx_valid) n_vcyc <= n_vcyc + 1;
    if (rx_valid && !pv) begin
      n_vrise   <= n_vrise + 1;
      vrise_cyc <= cyc;
    end
    if (!busy && pb) bfall_cyc <= cyc;
    if (frame_err) n_fe <= n_fe + 1;
    if (overrun) n_ovr <= n_ovr + 1;
    if (rx_valid && rx_ready) begin
      got_mem[n_got % 64] <= rx_data;
      n_got <= n_got + 1;
    end
    pv <= rx_valid;
    pb <= busy;
  end

  int            n_fe_f = 0, n_ovr_f = 0, n_got_f = 0;
  logic [FW-1:0] gotf_mem [0:127];
  always @(negedge clk) begin
    if (frame_err_f) n_fe_f <= n_fe_f + 1;
    if (overrun_f) n_ovr_f <= n_ovr_f + 1;
    if (rx_valid_f && rx_ready_f) begin
      gotf_mem[n_got_f % 128] <= rx_data_f;
      n_got_f <= n_got_f + 1;
    end
  end

  int checks = 0, errors = 0;
  task automatic chk(input string tag, input longint obs, input longint exp, input longint tol = 0);
    checks++;
    if (obs < exp - tol || obs > exp + tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_line(input bit fast, input logic v);
    if (fast) rxd_f = v;
    else      rxd   = v;
  endtask

  int t_edge = 0, t_hi = 0;
  task automatic send_body(input bit fast, input logic [8:0] d, input int nb, input logic stopv);
    int bp;
    bp = fast ? FBIT : BIT;
    set_line(fast, 1'b0);
    t_edge = cyc;
    tick(bp);
    for (int i = 0; i < nb; i++) begin
      set_line(fast, d[i]);
      tick(bp);
    end
    set_line(fast, stopv);
    tick(bp);
  endtask

  task automatic line_high(input bit fast, input int gap);
    set_line(fast, 1'b1);
    t_hi = cyc;
    tick(gap);
  endtask

  logic [FW-1:0] exp_mem [0:127];

  initial begin
    int            v0, r0, f0, o0, g0, gf0, ff0, of0;
    int            exp_fe, exp_ovr, n_exp;
    logic [31:0]   rnd;
    logic [FW-1:0] w, mdata;
    bit            good, r, mvalid;

    reset = 1'b0; rxd = 1'b1; rx_ready = 1'b1; rxd_f = 1'b1; rx_ready_f = 1'b0;
    tick(1);
    for (int i = 0; i < 5; i++) begin
      rxd = i[0];
      tick(1);
      chk("rst_outputs", {rx_data, rx_valid, frame_err, overrun, busy}, 0);
    end
    chk("rst_outputs_fast", {rx_data_f, rx_valid_f, frame_err_f, overrun_f, busy_f}, 0);
    rxd = 1'b1;
    tick(1);
    reset = 1'b1;
    tick(10);

    // Nominal frame with a consumer that is always ready.
    v0 = n_vcyc; r0 = n_vrise; f0 = n_fe; o0 = n_ovr; g0 = n_got;
    send_body(1'b0, 9'h0A5, 8, 1'b1);
    line_high(1'b0, 100);
    chk("a5_vrise", n_vrise - r0, 1);
    chk("a5_vcycles", n_vcyc - v0, 1);
    chk("a5_ngot", n_got - g0, 1);
    chk("a5_data", got_mem[g0 % 64], 8'hA5);
    chk("a5_latency", vrise_cyc - t_edge, 10310, 3);
    chk("a5_frame_err", n_fe - f0, 0);
    chk("a5_overrun", n_ovr - o0, 0);

    // Short low glitch is a false start.
    r0 = n_vrise; f0 = n_fe;
    set_line(1'b0, 1'b0);
    t_edge = cyc;
    tick(300);
    line_high(1'b0, 800);
    chk("glitch_vrise", n_vrise - r0, 0);
    chk("glitch_frame_err", n_fe - f0, 0);
    chk("glitch_busy_fall", bfall_cyc - t_edge, 545, 3);
    chk("glitch_idle", busy, 0);

    // Low stop bit followed by a break.
    r0 = n_vrise; f0 = n_fe;
    send_body(1'b0, 9'h03C, 8, 1'b0);
    tick(3 * BIT);
    chk("brk_busy_held", busy, 1);
    line_high(1'b0, 30);
    chk("brk_frame_err", n_fe - f0, 1);
    chk("brk_vrise", n_vrise - r0, 0);
    chk("brk_release", bfall_cyc - t_hi, 3, 1);
    chk("brk_idle", busy, 0);

    // Back-to-back frames with a stalled consumer.
    rx_ready = 1'b0;
    o0 = n_ovr; g0 = n_got;
    send_body(1'b0, 9'h011, 8, 1'b1);
    send_body(1'b0, 9'h022, 8, 1'b1);
    line_high(1'b0, 20);
    chk("ovr_pulses", n_ovr - o0, 1);
    chk("ovr_valid", rx_valid, 1);
    chk("ovr_data", rx_data, 8'h11);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    tick(2);
    chk("ovr_cleared", rx_valid, 0);
    chk("ovr_ngot", n_got - g0, 1);
    chk("ovr_got", got_mem[g0 % 64], 8'h11);

    // Reset in the middle of data bit 3 of an all-ones frame.
    rx_ready = 1'b1;
    set_line(1'b0, 1'b0);
    tick(BIT);
    set_line(1'b0, 1'b1);
    tick(3 * BIT + BIT / 2);
    chk("midrst_busy_before", busy, 1);
    #1 reset = 1'b0;
    #1 chk("midrst_outputs", {rx_data, rx_valid, frame_err, overrun, busy}, 0);
    tick(3);
    reset = 1'b1;
    tick(200);
    f0 = n_fe; g0 = n_got;
    send_body(1'b0, 9'h05A, 8, 1'b1);
    line_high(1'b0, 100);
    chk("post_rst_ngot", n_got - g0, 1);
    chk("post_rst_data", got_mem[g0 % 64], 8'h5A);
    chk("post_rst_frame_err", n_fe - f0, 0);

    // Randomized frames on the fast instance against a frame-level model.
    mvalid = 1'b0; mdata = '0; exp_fe = 0; exp_ovr = 0; n_exp = 0;
    gf0 = n_got_f; ff0 = n_fe_f; of0 = n_ovr_f;
    for (int k = 0; k < 40; k++) begin
      rnd  = $urandom;
      w    = rnd[FW-1:0];
      good = ($urandom_range(0, 4) != 0);
      r    = ($urandom_range(0, 1) == 1);
      rx_ready_f = r;
      tick(1);
      if (r && mvalid) begin
        exp_mem[n_exp] = mdata;
        n_exp++;
        mvalid = 1'b0;
      end
      send_body(1'b1, {2'b00, w}, FW, good);
      if (!good) begin
        tick(FBIT * $urandom_range(0, 2));
        exp_fe++;
      end else if (r) begin
        exp_mem[n_exp] = w;
        n_exp++;
      end else if (!mvalid) begin
        mvalid = 1'b1;
        mdata  = w;
      end else begin
        exp_ovr++;
      end
      line_high(1'b1, $urandom_range(2, 40));
      chk("rnd_valid", rx_valid_f, mvalid);
      if (mvalid) chk("rnd_data", rx_data_f, mdata);
    end
    rx_ready_f = 1'b1;
    tick(2);
    if (mvalid) begin
      exp_mem[n_exp] = mdata;
      n_exp++;
    end
    rx_ready_f = 1'b0;
    tick(2);
    chk("rnd_frame_err", n_fe_f - ff0, exp_fe);
    chk("rnd_overrun", n_ovr_f - of0, exp_ovr);
    chk("rnd_ngot", n_got_f - gf0, n_exp);
    for (int i = 0; i < n_exp; i++) begin
      chk("rnd_word", gotf_mem[(gf0 + i) % 128], exp_mem[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
